// File: rtl/cache_control_nway.sv
// N-way set-associative write-back cache controller: hit/miss, dirty write-back, fill, allocate.
// Optional performance counters (hit_cnt, miss_cnt, wb_cnt) are built when CACHE_PERF_CNT_EN is defined.
module cache_control_nway #(
  parameter int WAYS = 4,
  localparam int WB = $clog2(WAYS),
  localparam int PB = WAYS - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [WAYS-1:0] hit,
  input  logic [WAYS-1:0] valid,
  input  logic [WAYS-1:0] dirty,
  input  logic [PB-1:0] plru_in,
  input  logic          pmem_resp,
  output logic          mem_resp,
  output logic [WAYS-1:0] way_sel,
  output logic          tag_write,
  output logic          valid_write,
  output logic          data_write,
  output logic          save_to_cache_sel,
  output logic          dirty_set,
  output logic          dirty_reset,
  output logic          plru_write,
  output logic [PB-1:0] plru_out,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic          pmem_addr_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt,
  output logic [31:0]   wb_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL, S_ALLOCATE} state_t;

  state_t          r_state, w_next;
  logic [WB-1:0]   r_vic, w_vic_next;
  logic            w_req, w_hit_any, w_wb_needed;
  logic [WB-1:0]   w_hit_idx, w_inv_idx, w_choose;
  logic [WAYS-1:0] w_hit_oh, w_vic_oh;

  // Tree walk: node 0 is the root, children of node n are 2n+1 / 2n+2; a 0 bit points low.
  function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] bits, input logic [WB-1:0] w);
    int   n;
    logic b;
    plru_touch = bits;
    n = 0;
    for (int l = 0; l < WB; l++) begin
      b = w[WB-1-l];
      for (int k = 0; k < PB; k++)
        if (k == n) plru_touch[k] = ~b;
      n = 2 * n + 1 + int'(b);
    end
  endfunction

  function automatic logic [WB-1:0] plru_victim(input logic [PB-1:0] bits);
    int   n;
    logic b;
    n = 0;
    for (int l = 0; l < WB; l++) begin
      b = 1'b0;
      for (int k = 0; k < PB; k++)
        if (k == n) b = bits[k];
      n = 2 * n + 1 + int'(b);
    end
    return WB'(n - PB);
  endfunction

  assign w_req     = mem_read | mem_write;
  assign w_hit_any = |hit;

  // Descending scans leave the lowest matching index in place.
  always_comb begin
    w_hit_idx = '0;
    w_inv_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i])   w_hit_idx = WB'(i);
      if (!valid[i]) w_inv_idx = WB'(i);
    end
  end

  assign w_choose    = (&valid) ? plru_victim(plru_in) : w_inv_idx;
  assign w_wb_needed = valid[w_choose] & dirty[w_choose];
  assign w_hit_oh    = WAYS'(1) << w_hit_idx;
  assign w_vic_oh    = WAYS'(1) << r_vic;

  // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    w_next            = r_state;
    w_vic_next        = r_vic;
    mem_resp          = 1'b0;
    way_sel           = '0;
    tag_write         = 1'b0;
    valid_write       = 1'b0;
    data_write        = 1'b0;
    save_to_cache_sel = 1'b0;
    dirty_set         = 1'b0;
    dirty_reset       = 1'b0;
    plru_write        = 1'b0;
    plru_out          = '0;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    pmem_addr_sel     = 1'b0;
    // Outputs stay quiet while reset is held, even with a hit presented.
    if (rst_n) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req && w_hit_any) begin
            mem_resp   = 1'b1;
            way_sel    = w_hit_oh;
            plru_write = 1'b1;
            plru_out   = plru_touch(plru_in, w_hit_idx);
            if (mem_write) begin
              data_write        = 1'b1;
              save_to_cache_sel = 1'b1;
              dirty_set         = 1'b1;
            end
          end else if (w_req) begin
            w_vic_next = w_choose;
            w_next     = w_wb_needed ? S_WRITEBACK : S_FILL;
          end
        end
        S_WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = w_vic_oh;
          if (pmem_resp) w_next = S_FILL;
        end
        S_FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) w_next = S_ALLOCATE;
        end
        S_ALLOCATE: begin
          way_sel     = w_vic_oh;
          tag_write   = 1'b1;
          valid_write = 1'b1;
          data_write  = 1'b1;
          dirty_reset = 1'b1;
          plru_write  = 1'b1;
          plru_out    = plru_touch(plru_in, r_vic);
          w_next      = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vic   <= '0;
    end else begin
      r_state <= w_next;
      r_vic   <= w_vic_next;
    end
  end

  always @(posedge clk) begin
    if (rst_n && r_state == S_IDLE && w_req)
      assert ($onehot0(hit)) else $error("cache_control_nway: multiple hit bits set (%b)", hit);
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
  logic        w_hit_evt, w_miss_evt, w_wb_evt;

  assign w_hit_evt  = rst_n && r_state == S_IDLE && w_req && w_hit_any;
  assign w_miss_evt = rst_n && r_state == S_IDLE && w_req && !w_hit_any;
  assign w_wb_evt   = rst_n && r_state == S_WRITEBACK && pmem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_hit_evt  && r_hit_cnt  != '1) r_hit_cnt  <= r_hit_cnt  + 32'd1;
      if (w_miss_evt && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_wb_evt   && r_wb_cnt   != '1) r_wb_cnt   <= r_wb_cnt   + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS = 4): hits, clean/dirty misses, reset mid-miss, withdrawal.
module tb_cache_control_nway;

  logic       clk = 1'b0;
  logic       rst_n, mem_read, mem_write, pmem_resp;
  logic [3:0] hit, valid, dirty, way_sel;
  logic [2:0] plru_in, plru_out;
  logic       mem_resp, tag_write, valid_write, data_write, save_to_cache_sel;
  logic       dirty_set, dirty_reset, plru_write, pmem_read, pmem_write, pmem_addr_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int n_overlap = 0;
  int bad;
  logic [17:0] obs, exp;

  cache_control_nway #(.WAYS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .valid(valid), .dirty(dirty), .plru_in(plru_in), .pmem_resp(pmem_resp),
    .mem_resp(mem_resp), .way_sel(way_sel), .tag_write(tag_write), .valid_write(valid_write),
    .data_write(data_write), .save_to_cache_sel(save_to_cache_sel), .dirty_set(dirty_set),
    .dirty_reset(dirty_reset), .plru_write(plru_write), .plru_out(plru_out),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {mem_resp, way_sel, tag_write, valid_write, data_write, save_to_cache_sel,
                dirty_set, dirty_reset, plru_write, plru_out, pmem_read, pmem_write, pmem_addr_sel};

  always @(negedge clk) if (pmem_read && pmem_write) n_overlap++;

  function automatic logic [17:0] ob(logic resp, logic [3:0] ws, logic tw, logic vw, logic dw,
                                     logic sc, logic ds, logic dr, logic pw, logic [2:0] po,
                                     logic pr, logic pwr, logic pas);
    return {resp, ws, tw, vw, dw, sc, ds, dr, pw, po, pr, pwr, pas};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; hit = 4'b0100; valid = 4'b1111;
    dirty = 4'b0000; plru_in = 3'b000; pmem_resp = 1'b0;
    #2;
    exp = '0;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, exp); end
    n_cmp++;
    mem_read = 1'b0; hit = 4'b0000;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_read_hit;
    mem_read = 1'b1; hit = 4'b0100; valid = 4'b1111; dirty = 4'b0000; plru_in = 3'b000;
    #1;
    exp = ob(1, 4'b0100, 0, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL read_hit: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    mem_read = 1'b0; hit = 4'b0000;
    #1;
    exp = '0;
    if (obs !== exp) begin n_fail++; $display("FAIL idle_after_hit: got %b want %b", obs, exp); end
    n_cmp++;
  endtask

  task automatic test_write_miss;
    mem_write = 1'b1; hit = 4'b0000; valid = 4'b1011; dirty = 4'b0000; plru_in = 3'b000;
    #1;
    exp = '0;
    if (obs !== exp) begin n_fail++; $display("FAIL wmiss_idle: got %b want %b", obs, exp); end
    n_cmp++;
    tick; #1;
    exp = ob(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL wmiss_fill: got %b want %b", obs, exp); end
    n_cmp++;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (obs !== exp) bad++;
    end
    if (bad !== 0) begin n_fail++; $display("FAIL wmiss_fill_hold: got %0d bad cycles want 0", bad); end
    n_cmp++;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    #1;
    exp = ob(0, 4'b0100, 1, 1, 1, 0, 0, 1, 1, 3'b100, 0, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL wmiss_alloc: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    hit = 4'b0100; valid = 4'b1111; plru_in = 3'b100;
    #1;
    exp = ob(1, 4'b0100, 0, 0, 1, 1, 1, 0, 1, 3'b100, 0, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL wmiss_replay: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    mem_write = 1'b0; hit = 4'b0000;
  endtask

  task automatic test_dirty_miss;
    mem_read = 1'b1; hit = 4'b0000; valid = 4'b1111; dirty = 4'b0001; plru_in = 3'b000;
    #1;
    exp = '0;
    if (obs !== exp) begin n_fail++; $display("FAIL dmiss_idle: got %b want %b", obs, exp); end
    n_cmp++;
    tick; #1;
    exp = ob(0, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL dmiss_wb: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    pmem_resp = 1'b1;
    #1;
    if (obs !== exp) begin n_fail++; $display("FAIL dmiss_wb_hold: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    pmem_resp = 1'b0;
    #1;
    exp = ob(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL dmiss_fill: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    #1;
    exp = ob(0, 4'b0001, 1, 1, 1, 0, 0, 1, 1, 3'b011, 0, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL dmiss_alloc: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    hit = 4'b0001; dirty = 4'b0000; plru_in = 3'b011;
    #1;
    exp = ob(1, 4'b0001, 0, 0, 0, 0, 0, 0, 1, 3'b011, 0, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL dmiss_replay: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    mem_read = 1'b0; hit = 4'b0000;
  endtask

  task automatic test_counters(input logic [31:0] e_hit, input logic [31:0] e_miss,
                               input logic [31:0] e_wb, input string tag);
`ifdef CACHE_PERF_CNT_EN
    #1;
    if (hit_cnt !== e_hit) begin n_fail++; $display("FAIL %s hit_cnt: got %0d want %0d", tag, hit_cnt, e_hit); end
    n_cmp++;
    if (miss_cnt !== e_miss) begin n_fail++; $display("FAIL %s miss_cnt: got %0d want %0d", tag, miss_cnt, e_miss); end
    n_cmp++;
    if (wb_cnt !== e_wb) begin n_fail++; $display("FAIL %s wb_cnt: got %0d want %0d", tag, wb_cnt, e_wb); end
    n_cmp++;
`else
    #1;
    if (tag.len() == 0) $display("counter check %0d %0d %0d", e_hit, e_miss, e_wb);
`endif
  endtask

  task automatic test_reset_mid_fill;
    mem_read = 1'b1; hit = 4'b0000; valid = 4'b0111; dirty = 4'b0000; plru_in = 3'b000;
    tick; #1;
    exp = ob(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL rmf_fill: got %b want %b", obs, exp); end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    exp = '0;
    if (obs !== exp) begin n_fail++; $display("FAIL rmf_async_drop: got %b want %b", obs, exp); end
    n_cmp++;
    mem_read = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (obs !== 18'd0) bad++;
      tick;
    end
    if (bad !== 0) begin n_fail++; $display("FAIL rmf_no_alloc: got %0d active cycles want 0", bad); end
    n_cmp++;
  endtask

  task automatic test_both_and_withdraw;
    mem_read = 1'b1; mem_write = 1'b1; hit = 4'b0010; valid = 4'b1111; dirty = 4'b0000;
    plru_in = 3'b000;
    #1;
    exp = ob(1, 4'b0010, 0, 0, 1, 1, 1, 0, 1, 3'b001, 0, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL both_hit_write: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    mem_write = 1'b0; hit = 4'b0000; dirty = 4'b1111; plru_in = 3'b101;
    tick; #1;
    exp = ob(0, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1);
    if (obs !== exp) begin n_fail++; $display("FAIL wd_wb: got %b want %b", obs, exp); end
    n_cmp++;
    mem_read = 1'b0;
    #1;
    if (obs !== exp) begin n_fail++; $display("FAIL wd_wb_dropped: got %b want %b", obs, exp); end
    n_cmp++;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    #1;
    exp = ob(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL wd_fill: got %b want %b", obs, exp); end
    n_cmp++;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    #1;
    exp = ob(0, 4'b1000, 1, 1, 1, 0, 0, 1, 1, 3'b000, 0, 0, 0);
    if (obs !== exp) begin n_fail++; $display("FAIL wd_alloc: got %b want %b", obs, exp); end
    n_cmp++;
    tick;
    hit = 4'b1000; dirty = 4'b0111; plru_in = 3'b000;
    #1;
    exp = '0;
    if (obs !== exp) begin n_fail++; $display("FAIL wd_no_resp: got %b want %b", obs, exp); end
    n_cmp++;
    pmem_resp = 1'b1;
    tick;
    pmem_resp = 1'b0;
    #1;
    if (obs !== exp) begin n_fail++; $display("FAIL idle_ignores_pmem_resp: got %b want %b", obs, exp); end
    n_cmp++;
  endtask

  task automatic test_no_overlap;
    if (n_overlap !== 0) begin n_fail++; $display("FAIL pmem_overlap: got %0d cycles want 0", n_overlap); end
    n_cmp++;
  endtask

  initial begin
    test_reset;
    test_counters(32'd0, 32'd0, 32'd0, "after_reset");
    test_read_hit;
    test_write_miss;
    test_dirty_miss;
    test_counters(32'd3, 32'd2, 32'd1, "mid_run");
    test_reset_mid_fill;
    test_both_and_withdraw;
    test_counters(32'd1, 32'd1, 32'd1, "end_run");
    test_no_overlap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

endmodule
